// File: rtl/graph_unary_lut_fp16.sv
// Per-lane FP16 unary function via loadable lookup tables indexed by the upper
// operand bits; 2-stage pipeline (table read, output register) with backpressure.
module graph_unary_lut_fp16 #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned NUM_TABLES = 4,
  localparam int unsigned TW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [TW-1:0]           cfg_table,
  input  logic [INDEX_BITS-1:0]   cfg_addr,
  input  logic [15:0]             cfg_wdata,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TW-1:0]           in_table,
  input  logic [16*LANES-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*LANES-1:0]     out_data,
  output logic                    busy
);

  localparam int unsigned DW    = 16 * LANES;
  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [15:0] QNAN  = 16'h7E00;
  localparam longint LN2_Q32    = 64'sd2977044472;

  typedef logic [DEPTH-1:0][15:0] tab_t;

  // fp16(ln(x)) for x = {idx, 8'h00}; magnitudes kept as Q32 fixed point
  function automatic logic [15:0] ln_entry(input logic [7:0] idx);
    logic [4:0]  e;
    logic [1:0]  m;
    int          ex;
    int          mi;
    int          p;
    longint      v;
    logic [63:0] a;
    logic [63:0] q;
    logic        s;
    e = idx[6:2];
    m = idx[1:0];
    if (idx == 8'h00 || idx == 8'h80) return 16'hFC00;
    if (idx[7]) return QNAN;
    if (e == 5'd31) return (m == 2'd0) ? 16'h7C00 : QNAN;
    if (e == 5'd0) begin
      // denormal: m * 2^-16 rewritten as mantissa * 2^ex
      ex = (m == 2'd1) ? -16 : -15;
      mi = (m == 2'd3) ? 2 : 0;
    end else begin
      ex = int'(e) - 15;
      mi = int'(m);
    end
    case (mi)
      1:       v = 64'sd958394255;
      2:       v = 64'sd1741459379;
      3:       v = 64'sd2403531507;
      default: v = 64'sd0;
    endcase
    v = v + longint'(ex) * LN2_Q32;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    a = s ? 64'(-v) : 64'(v);
    p = 0;
    for (int b = 0; b < 64; b++) if (a[b]) p = b;
    q = a >> (p - 10);
    q = q + {63'd0, a[p-11]};
    if (q == 64'd2048) begin
      q = 64'd1024;
      p = p + 1;
    end
    return {s, 5'(p - 17), 10'(q)};
  endfunction

  function automatic tab_t ln_rom();
    tab_t r;
    for (int i = 0; i < int'(DEPTH); i++) r[i] = ln_entry(8'(i));
    return r;
  endfunction

  logic                  s1_valid;
  logic [TW-1:0]         s1_table;
  logic                  s1_oor;
  logic [DW-1:0]         s1_result;
  logic [DW-1:0]         rd_data [NUM_TABLES];
  logic [INDEX_BITS-1:0] idx [LANES];
  logic                  accept;
  logic                  s2_en;
  logic                  in_ok;
  logic                  cfg_ok;
  logic                  wr_en;
  logic                  unused;

  assign unused = ^in_data;

  assign busy     = s1_valid || out_valid;
  assign s2_en    = !out_valid || out_ready;
  assign in_ready = !rst && !cfg_we && !(s1_valid && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign in_ok    = 32'(in_table) < NUM_TABLES;
  assign cfg_ok   = 32'(cfg_table) < NUM_TABLES;
  assign wr_en    = cfg_we && !busy && cfg_ok && !rst;

  always_comb begin
    for (int k = 0; k < int'(LANES); k++)
      idx[k] = in_data[16*k + 16 - INDEX_BITS +: INDEX_BITS];
  end

  // One memory per table; the read port only fires for transfers aimed at it
  for (genvar t = 0; t < int'(NUM_TABLES); t++) begin : g_tab
    tab_t          mem = (t == 0 && INDEX_BITS == 8) ? ln_rom() : '0;
    logic [DW-1:0] rd;

    always_ff @(posedge clk) begin
      if (wr_en && cfg_table == TW'(t)) mem[cfg_addr] <= cfg_wdata;
      if (accept && in_table == TW'(t)) begin
        for (int k = 0; k < int'(LANES); k++) rd[16*k +: 16] <= mem[idx[k]];
      end
    end

    assign rd_data[t] = rd;
  end

  always_comb begin
    s1_result = {LANES{QNAN}};
    if (!s1_oor) begin
      for (int t = 0; t < int'(NUM_TABLES); t++)
        if (s1_table == TW'(t)) s1_result = rd_data[t];
    end
  end

  // Pipeline control; stage 1 only refills when stage 2 can take its contents
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (busy || !cfg_ok);
      if (s2_en) out_valid <= s1_valid;
      if (s2_en || !s1_valid) s1_valid <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_table <= in_table;
      s1_oor   <= !in_ok;
    end
    if (s2_en && s1_valid) out_data <= s1_result;
  end

endmodule

// File: tb/tb_graph_unary_lut_fp16.sv
// Randomized and directed bench for graph_unary_lut_fp16 against a queue-based
// transfer model and a real-arithmetic ln reference for table 0.
module tb_graph_unary_lut_fp16;

  localparam int unsigned LANES = 4;
  localparam int unsigned IB    = 8;
  localparam int unsigned NT    = 3;
  localparam int unsigned TW    = 2;
  localparam int unsigned DW    = 16 * LANES;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [TW-1:0] cfg_table;
  logic [IB-1:0] cfg_addr;
  logic [15:0]   cfg_wdata;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_table;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  graph_unary_lut_fp16 #(.LANES(LANES), .INDEX_BITS(IB), .NUM_TABLES(NT)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_table(cfg_table), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_table(in_table), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference ln from the decoded fp16 value using real arithmetic
  function automatic logic [15:0] ref_ln(input int idx);
    real x, v, a;
    int  e, m, ex, q;
    logic s;
    e = (idx >> 2) & 31;
    m = idx & 3;
    if (idx == 8'h80 || idx == 0) return 16'hFC00;
    if (idx >= 128) return 16'h7E00;
    if (e == 31) return (m == 0) ? 16'h7C00 : 16'h7E00;
    if (e == 0) begin
      x = m;
      for (int i = 0; i < 16; i++) x = x / 2.0;
    end else begin
      x = 1.0 + m / 4.0;
      for (int i = 0; i < e - 15; i++) x = x * 2.0;
      for (int i = 0; i < 15 - e; i++) x = x / 2.0;
    end
    v = $ln(x);
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    ex = 0;
    while (a >= 2.0) begin a = a / 2.0; ex++; end
    while (a < 1.0) begin a = a * 2.0; ex--; end
    q = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (q == 1024) begin q = 0; ex++; end
    return {s, 5'(ex + 15), 10'(q)};
  endfunction

  logic [15:0] tab [NT][256];

  function automatic logic [DW-1:0] lookup(input logic [TW-1:0] t, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic [7:0]    ix;
    for (int k = 0; k < int'(LANES); k++) begin
      ix = d[16*k + 8 +: 8];
      r[16*k +: 16] = (32'(t) >= NT) ? 16'h7E00 : tab[t][ix];
    end
    return r;
  endfunction

  typedef struct { logic [DW-1:0] data; int acc; } ent_t;
  ent_t q[$];
  int   cyc = 0;
  int   n_out_dut = 0;
  bit   err_exp = 0;
  bit   rst_prev = 0;

  // Model tracks transfers in flight; outputs compared every cycle
  always @(negedge clk) begin
    bit   exp_valid;
    bit   exp_ready;
    ent_t e;
    cyc++;
    if (rst) begin
      chk("in_ready_in_rst", 64'(in_ready), 64'd0);
      if (rst_prev) begin
        chk("out_valid_in_rst", 64'(out_valid), 64'd0);
        chk("busy_in_rst", 64'(busy), 64'd0);
        chk("cfg_err_in_rst", 64'(cfg_err), 64'd0);
      end
      q.delete();
      err_exp = 0;
    end else begin
      exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 2);
      exp_ready = !cfg_we && !(q.size() == 2 && !out_ready);
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("cfg_err", 64'(cfg_err), 64'(err_exp));
      if (exp_valid) chk("out_data", out_data, q[0].data);
      if (out_valid && out_ready) n_out_dut++;
      err_exp = cfg_we && (q.size() != 0 || 32'(cfg_table) >= NT);
      if (cfg_we && q.size() == 0 && 32'(cfg_table) < NT) tab[cfg_table][cfg_addr] = cfg_wdata;
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        e.data = lookup(in_table, in_data);
        e.acc  = cyc;
        q.push_back(e);
      end
    end
    rst_prev = rst;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 0;
    cfg_we = 0;
    out_ready = 1;
    for (int i = 0; i < 8 && busy; i++) cycle();
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  task automatic cfg_write(input logic [TW-1:0] t, input logic [7:0] a, input logic [15:0] d);
    cfg_we = 1; cfg_table = t; cfg_addr = a; cfg_wdata = d;
    cycle();
    cfg_we = 0;
  endtask

  // Directed lookup from an idle pipeline with literal expectation
  task automatic look(input string name, input logic [TW-1:0] t, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp);
    out_ready = 1;
    in_valid = 1; in_table = t; in_data = d;
    cycle();
    in_valid = 0;
    chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    cycle();
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk(name, out_data, exp);
    cycle();
  endtask

  initial begin
    int sent;
    int n0;
    rst = 1; cfg_we = 0; cfg_table = 0; cfg_addr = 0; cfg_wdata = 0;
    in_valid = 0; in_table = 0; in_data = 0; out_ready = 1;
    for (int i = 0; i < 256; i++) tab[0][i] = ref_ln(i);
    chk("model_ln_3c", 64'(tab[0][8'h3C]), 64'h0000);
    chk("model_ln_40", 64'(tab[0][8'h40]), 64'h398C);
    chk("model_ln_7d", 64'(tab[0][8'h7D]), 64'h7E00);

    repeat (3) cycle();
    rst = 0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    cycle();

    look("ln_vector", 2'd0, {16'hBC00, 16'h0000, 16'h4000, 16'h3C00},
         {16'h7E00, 16'hFC00, 16'h398C, 16'h0000});

    for (int t = 1; t < int'(NT); t++)
      for (int a = 0; a < 256; a++) begin
        cfg_we = 1; cfg_table = TW'(t); cfg_addr = 8'(a); cfg_wdata = 16'($urandom);
        cycle();
      end
    cfg_we = 0;
    cfg_write(2'd1, 8'h3C, 16'h1234);
    look("tab1_3c", 2'd1, {4{16'h3C55}}, {4{16'h1234}});
    look("tab_oor", 2'd3, {4{16'h3C55}}, {4{16'h7E00}});

    cfg_write(2'd3, 8'h00, 16'hAAAA);
    chk("cfg_err_oor", 64'(cfg_err), 64'd1);
    cycle();
    chk("cfg_err_oor_end", 64'(cfg_err), 64'd0);

    out_ready = 0;
    in_valid = 1; in_table = 2'd1; in_data = {4{16'h3C00}};
    cycle();
    in_valid = 0;
    cfg_write(2'd1, 8'h3C, 16'hBEEF);
    chk("cfg_err_busy", 64'(cfg_err), 64'd1);
    cycle();
    chk("cfg_err_busy_end", 64'(cfg_err), 64'd0);
    drain();
    look("tab1_3c_kept", 2'd1, {4{16'h3C00}}, {4{16'h1234}});

    cfg_we = 1; cfg_table = 2'd2; cfg_addr = 8'h10; cfg_wdata = 16'h5555;
    in_valid = 1; in_table = 2'd2; in_data = {4{16'h1000}};
    #2;
    chk("cfg_priority_ready", 64'(in_ready), 64'd0);
    cycle();
    cfg_we = 0; in_valid = 0;
    cycle();
    chk("cfg_priority_busy", 64'(busy), 64'd0);
    look("tab2_10", 2'd2, {4{16'h10FF}}, {4{16'h5555}});

    n0 = n_out_dut;
    sent = 0;
    for (int c = 0; c < 200 && sent < 16; c++) begin
      in_valid = 1; in_table = TW'($urandom_range(0, 2));
      in_data = {$urandom, $urandom};
      out_ready = c[0];
      #2;
      if (in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    chk("stream_sent", 64'(sent), 64'd16);
    drain();
    chk("stream_out", 64'(n_out_dut - n0), 64'd16);

    out_ready = 0;
    in_valid = 1; in_table = 2'd0; in_data = {$urandom, $urandom};
    cycle();
    in_data = {$urandom, $urandom};
    cycle();
    in_valid = 0;
    chk("two_in_flight", 64'(busy), 64'd1);
    rst = 1;
    cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 0;
    cycle();
    look("tab1_after_rst", 2'd1, {4{16'h3C01}}, {4{16'h1234}});

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_table = TW'($urandom_range(0, 3));
      cfg_addr  = 8'($urandom);
      cfg_wdata = 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_table  = ($urandom_range(0, 7) == 0) ? 2'd3 : TW'($urandom_range(0, 2));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    rst = 0;
    drain();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
